lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: TIMEOUT, 16, number of WAIT-state cycles without lsu_i_bus_rvalid before the access is aborted (range 2..255).
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset); deassertion synchronised externally.
REQ-004 lsu_i_valid  input  1  access request from the execute stage.
REQ-005 lsu_i_addr  input  32  byte address (ALU result of the execute stage).
REQ-006 lsu_i_wdata  input  32  store data (rs2 pass-through of the execute stage).
REQ-007 lsu_i_we  input  1  1 = store, 0 = load.
REQ-008 lsu_i_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 lsu_i_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 lsu_o_ready  output  1  high only in IDLE; request accepted when lsu_i_valid & lsu_o_ready.
REQ-011 lsu_o_done  output  1  one-cycle pulse: access completed.
REQ-012 lsu_o_rdata  output  32  load result, valid when lsu_o_done=1; 0 for stores.
REQ-013 lsu_o_err  output  1  one-cycle pulse: misaligned/illegal request or bus timeout.
REQ-014 lsu_o_bus_req / lsu_o_bus_we  output  1 each  bus request and write enable.
REQ-015 lsu_o_bus_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-016 lsu_o_bus_wstrb  output  4  byte-lane strobes; lsu_o_bus_wdata  output  32  lane-replicated store data.
REQ-017 lsu_i_bus_gnt  input  1  bus accepts request; lsu_i_bus_rvalid  input  1  response (load data or store ack); lsu_i_bus_rdata  input  32  load word.

Function
REQ-018 FSM states IDLE, REQ, WAIT; request fields latched on acceptance and held constant until return to IDLE.
REQ-019 IDLE: on accept, misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11 -> stay IDLE, lsu_o_err=1 next cycle, no bus activity; else -> REQ.
REQ-020 REQ: lsu_o_bus_req=1 with addr/we/wstrb/wdata stable; on lsu_i_bus_gnt=1 -> WAIT and clear timeout counter.
REQ-021 WAIT: lsu_o_bus_req=0; lsu_i_bus_rvalid -> IDLE with lsu_o_done=1 next cycle; rvalid outside WAIT is ignored (earliest legal rvalid is cycle after gnt).
REQ-022 WAIT timeout: counter increments each WAIT cycle without rvalid; on reaching TIMEOUT -> IDLE, lsu_o_err=1 next cycle, no done.
REQ-023 Minimum latency: accept at cycle T, bus_req at T+1, gnt at T+1, rvalid at T+2, done at T+3; back-to-back accept allowed in the done cycle.
REQ-024 wstrb: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; loads drive wstrb=0.
REQ-025 wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-026 rdata: select lane by addr[1:0], extend to 32 bits per lsu_i_unsigned; registered, held until next done.
REQ-027 done and err never asserted in the same cycle.

Reset
REQ-028 rst=0 immediately forces IDLE: lsu_o_bus_req=0, lsu_o_bus_we=0, wstrb=0, done=0, err=0, rdata=0, counter=0; lsu_o_ready=1 while rst=1 and IDLE.
REQ-029 Reset mid-REQ/WAIT abandons the access: no done or err is ever produced for it; a late rvalid after reset is ignored.

Verification
REQ-030 Load byte addr=0x1003, unsigned=0, rdata=0x80FFFFFF, gnt/rvalid immediate -> bus_addr=0x1000, wstrb=0, done at T+3, lsu_o_rdata=0xFFFFFF80.
REQ-031 Store half addr=0x2002, wdata=0x1234ABCD, gnt delayed 3 cycles -> bus_req held 4 cycles, wstrb=4'b1100, bus_wdata=0xABCDABCD, done after rvalid, rdata=0.
REQ-032 Load word addr=0x3001 -> no bus_req, err=1 at T+1, ready=1 throughout; size=11 likewise errors.
REQ-033 Load word, gnt given, rvalid withheld (TIMEOUT=16) -> err=1 after 16 WAIT cycles, no done; subsequent rvalid ignored.
REQ-034 rst asserted during WAIT, then rvalid -> bus_req=0 immediately, no done/err, ready=1 after release.
REQ-035 Two back-to-back loads (halfword unsigned addr=0x0, 0x8000 -> 0x00008000; then word) -> second accepted in first done cycle, both results correct.

Source files
------------

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu -- load/store unit between the execute stage and a simple req/gnt/rvalid
// data bus.
//
// One access is in flight at a time. A request is taken in IDLE. Misaligned or
// illegal-size requests are rejected with a one-cycle error pulse and never
// reach the bus. Legal requests go through REQ (bus_req held until gnt) and
// WAIT (until rvalid, or until the timeout aborts the access).
//
// Ports
//   clk                sole clock, rising edge
//   rst                asynchronous reset, active low
//   lsu_i_valid        access request from execute
//   lsu_i_addr         byte address
//   lsu_i_wdata        store data
//   lsu_i_we           1 = store, 0 = load
//   lsu_i_size         00 byte, 01 half, 10 word, 11 illegal
//   lsu_i_unsigned     loads zero-extend when 1, sign-extend when 0
//   lsu_o_ready        high only in IDLE
//   lsu_o_done         one-cycle completion pulse
//   lsu_o_rdata        load result (0 for stores), held until the next done
//   lsu_o_err          one-cycle pulse: rejected request or bus timeout
//   lsu_o_bus_req      bus request (REQ state)
//   lsu_o_bus_we       bus write enable
//   lsu_o_bus_addr     word-aligned bus address
//   lsu_o_bus_wstrb    byte-lane strobes (0 for loads)
//   lsu_o_bus_wdata    lane-replicated store data
//   lsu_i_bus_gnt      bus accepts the request
//   lsu_i_bus_rvalid   bus response (load data or store ack)
//   lsu_i_bus_rdata    load word from the bus
// ---------------------------------------------------------------------------
module lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_i_valid,
  input  logic [31:0] lsu_i_addr,
  input  logic [31:0] lsu_i_wdata,
  input  logic        lsu_i_we,
  input  logic [1:0]  lsu_i_size,
  input  logic        lsu_i_unsigned,
  output logic        lsu_o_ready,
  output logic        lsu_o_done,
  output logic [31:0] lsu_o_rdata,
  output logic        lsu_o_err,
  output logic        lsu_o_bus_req,
  output logic        lsu_o_bus_we,
  output logic [31:0] lsu_o_bus_addr,
  output logic [3:0]  lsu_o_bus_wstrb,
  output logic [31:0] lsu_o_bus_wdata,
  input  logic        lsu_i_bus_gnt,
  input  logic        lsu_i_bus_rvalid,
  input  logic [31:0] lsu_i_bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        illegal_d;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  logic [31:0] laneShifted;
  logic [31:0] rdata_d;

  // Decode the incoming request: alignment check, byte strobes and
  // lane-replicated store data, all captured together on acceptance.
  always_comb begin
    illegal_d = 1'b0;
    wstrb_d   = 4'b0000;
    wdata_d   = lsu_i_wdata;
    case (lsu_i_size)
      SizeByte: begin
        wstrb_d = 4'b0001 << lsu_i_addr[1:0];
        wdata_d = {4{lsu_i_wdata[7:0]}};
      end
      SizeHalf: begin
        illegal_d = lsu_i_addr[0];
        wstrb_d   = 4'b0011 << lsu_i_addr[1:0];
        wdata_d   = {2{lsu_i_wdata[15:0]}};
      end
      SizeWord: begin
        illegal_d = (lsu_i_addr[1:0] != 2'b00);
        wstrb_d   = 4'b1111;
      end
      default: illegal_d = 1'b1;
    endcase
    if (!lsu_i_we) begin
      wstrb_d = 4'b0000;
    end
  end

  // Load result: move the addressed lane down to bit 0, then extend.
  always_comb begin
    laneShifted = lsu_i_bus_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      SizeByte: rdata_d = {{24{~unsigned_q & laneShifted[7]}}, laneShifted[7:0]};
      SizeHalf: rdata_d = {{16{~unsigned_q & laneShifted[15]}}, laneShifted[15:0]};
      default:  rdata_d = laneShifted;
    endcase
    if (we_q) begin
      rdata_d = 32'h0;
    end
  end

  // Main FSM. done/err are single-cycle pulses cleared by default every cycle;
  // an asynchronous reset abandons any in-flight access without a pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      addr_q     <= 32'h0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      wstrb_q    <= 4'b0000;
      wdata_q    <= 32'h0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (lsu_i_valid) begin
            if (illegal_d) begin
              err_q <= 1'b1;
            end else begin
              addr_q     <= lsu_i_addr;
              we_q       <= lsu_i_we;
              size_q     <= lsu_i_size;
              unsigned_q <= lsu_i_unsigned;
              wstrb_q    <= wstrb_d;
              wdata_q    <= wdata_d;
              state_q    <= REQ;
            end
          end
        end
        REQ: begin
          if (lsu_i_bus_gnt) begin
            cnt_q   <= 8'd0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (lsu_i_bus_rvalid) begin
            rdata_q <= rdata_d;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (cnt_q == TimeoutLast) begin
            // This is the TIMEOUT-th WAIT cycle without a response.
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lsu_o_ready     = (state_q == IDLE);
  assign lsu_o_done      = done_q;
  assign lsu_o_err       = err_q;
  assign lsu_o_rdata     = rdata_q;
  assign lsu_o_bus_req   = (state_q == REQ);
  assign lsu_o_bus_we    = we_q & (state_q != IDLE);
  assign lsu_o_bus_addr  = {addr_q[31:2], 2'b00};
  assign lsu_o_bus_wstrb = (state_q != IDLE) ? wstrb_q : 4'b0000;
  assign lsu_o_bus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu -- directed testbench for lsu. Inputs change 1ns after the rising
// edge and outputs are checked at the same point, so every check sees the
// state registered by the preceding edge.
// ---------------------------------------------------------------------------
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [1:0]  size;
  logic        unsignedLoad;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [3:0]  busWstrb;
  logic [31:0] busWdata;
  logic        busGnt;
  logic        busRvalid;
  logic [31:0] busRdata;

  int checkCount = 0;
  int errorCount = 0;

  lsu #(.TIMEOUT(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .lsu_i_valid      (valid),
    .lsu_i_addr       (addr),
    .lsu_i_wdata      (wdata),
    .lsu_i_we         (we),
    .lsu_i_size       (size),
    .lsu_i_unsigned   (unsignedLoad),
    .lsu_o_ready      (ready),
    .lsu_o_done       (done),
    .lsu_o_rdata      (rdata),
    .lsu_o_err        (err),
    .lsu_o_bus_req    (busReq),
    .lsu_o_bus_we     (busWe),
    .lsu_o_bus_addr   (busAddr),
    .lsu_o_bus_wstrb  (busWstrb),
    .lsu_o_bus_wdata  (busWdata),
    .lsu_i_bus_gnt    (busGnt),
    .lsu_i_bus_rvalid (busRvalid),
    .lsu_i_bus_rdata  (busRdata)
  );

  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] d,
                               input logic w, input logic [1:0] s, input logic u);
    valid        = v;
    addr         = a;
    wdata        = d;
    we           = w;
    size         = s;
    unsignedLoad = u;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b0;
    busGnt    = 1'b0;
    busRvalid = 1'b0;
    busRdata  = 32'h0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);

    // Reset state
    #12;
    checkOutput("reset_ready", ready, 1);
    checkOutput("reset_bus_req", busReq, 0);
    checkOutput("reset_bus_we", busWe, 0);
    checkOutput("reset_wstrb", busWstrb, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_rdata", rdata, 0);
    #7 rst = 1'b1;
    nextCycle();
    nextCycle();

    // Signed byte load, immediate gnt/rvalid
    $display("[TB] load byte 0x1003");
    applyStimulus(1'b1, 32'h0000_1003, 32'h0, 1'b0, 2'b00, 1'b0);
    checkOutput("lb_ready_T", ready, 1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
    checkOutput("lb_bus_req", busReq, 1);
    checkOutput("lb_bus_addr", busAddr, 32'h0000_1000);
    checkOutput("lb_wstrb", busWstrb, 0);
    checkOutput("lb_bus_we", busWe, 0);
    checkOutput("lb_ready_req", ready, 0);
    busGnt = 1'b1;
    nextCycle();
    busGnt = 1'b0;
    checkOutput("lb_bus_req_wait", busReq, 0);
    checkOutput("lb_done_early", done, 0);
    busRvalid = 1'b1;
    busRdata  = 32'h80FF_FFFF;
    nextCycle();
    busRvalid = 1'b0;
    busRdata  = 32'h0;
    checkOutput("lb_done", done, 1);
    checkOutput("lb_err", err, 0);
    checkOutput("lb_rdata", rdata, 32'hFFFF_FF80);
    checkOutput("lb_ready_done", ready, 1);
    nextCycle();
    checkOutput("lb_done_pulse", done, 0);
    checkOutput("lb_rdata_held", rdata, 32'hFFFF_FF80);

    // Halfword store, gnt delayed three cycles
    $display("[TB] store half 0x2002");
    applyStimulus(1'b1, 32'h0000_2002, 32'h1234_ABCD, 1'b1, 2'b01, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("sh_bus_req_%0d", i), busReq, 1);
      checkOutput($sformatf("sh_wstrb_%0d", i), busWstrb, 4'b1100);
      checkOutput($sformatf("sh_wdata_%0d", i), busWdata, 32'hABCD_ABCD);
      checkOutput($sformatf("sh_bus_we_%0d", i), busWe, 1);
      checkOutput($sformatf("sh_bus_addr_%0d", i), busAddr, 32'h0000_2000);
      busGnt = (i == 3);
      nextCycle();
    end
    busGnt = 1'b0;
    checkOutput("sh_bus_req_wait", busReq, 0);
    nextCycle();
    checkOutput("sh_done_early", done, 0);
    busRvalid = 1'b1;
    nextCycle();
    busRvalid = 1'b0;
    checkOutput("sh_done", done, 1);
    checkOutput("sh_rdata", rdata, 0);
    nextCycle();

    // Misaligned word and illegal size are rejected without bus activity
    $display("[TB] misaligned and illegal requests");
    applyStimulus(1'b1, 32'h0000_3001, 32'h0, 1'b0, 2'b10, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
    checkOutput("mis_err", err, 1);
    checkOutput("mis_done", done, 0);
    checkOutput("mis_bus_req", busReq, 0);
    checkOutput("mis_ready", ready, 1);
    nextCycle();
    checkOutput("mis_err_pulse", err, 0);
    checkOutput("mis_bus_req2", busReq, 0);
    applyStimulus(1'b1, 32'h0000_4000, 32'h0, 1'b0, 2'b11, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
    checkOutput("ill_err", err, 1);
    checkOutput("ill_bus_req", busReq, 0);
    checkOutput("ill_ready", ready, 1);
    nextCycle();
    applyStimulus(1'b1, 32'h0000_4001, 32'h0, 1'b1, 2'b01, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
    checkOutput("mis_half_err", err, 1);
    checkOutput("mis_half_bus_req", busReq, 0);
    nextCycle();

    // Bus timeout: gnt given, rvalid withheld
    $display("[TB] timeout");
    applyStimulus(1'b1, 32'h0000_5000, 32'h0, 1'b0, 2'b10, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
    busGnt = 1'b1;
    nextCycle();
    busGnt = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("to_err_wait_%0d", i), err, 0);
      checkOutput($sformatf("to_ready_wait_%0d", i), ready, 0);
      nextCycle();
    end
    checkOutput("to_err", err, 1);
    checkOutput("to_done", done, 0);
    checkOutput("to_ready", ready, 1);
    busRvalid = 1'b1;
    busRdata  = 32'h5555_5555;
    nextCycle();
    busRvalid = 1'b0;
    checkOutput("to_late_done", done, 0);
    checkOutput("to_late_err", err, 0);
    checkOutput("to_late_rdata", rdata, 0);
    nextCycle();
    checkOutput("to_late_done2", done, 0);

    // Reset during WAIT abandons the access
    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 32'h0000_6000, 32'h0, 1'b0, 2'b10, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
    busGnt = 1'b1;
    nextCycle();
    busGnt = 1'b0;
    checkOutput("rw_ready_wait", ready, 0);
    rst = 1'b0;
    #1;
    checkOutput("rw_bus_req", busReq, 0);
    checkOutput("rw_ready_reset", ready, 1);
    busRvalid = 1'b1;
    busRdata  = 32'hAAAA_AAAA;
    nextCycle();
    checkOutput("rw_done_in_reset", done, 0);
    #2 rst = 1'b1;
    nextCycle();
    checkOutput("rw_done_after", done, 0);
    checkOutput("rw_err_after", err, 0);
    checkOutput("rw_ready_after", ready, 1);
    checkOutput("rw_rdata_after", rdata, 0);
    busRvalid = 1'b0;
    busRdata  = 32'h0;
    nextCycle();
    checkOutput("rw_done_after2", done, 0);

    // Back-to-back loads: second accepted in the first done cycle
    $display("[TB] back-to-back loads");
    applyStimulus(1'b1, 32'h0000_0000, 32'h0, 1'b0, 2'b01, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
    busGnt = 1'b1;
    nextCycle();
    busGnt    = 1'b0;
    busRvalid = 1'b1;
    busRdata  = 32'h0000_8000;
    nextCycle();
    busRvalid = 1'b0;
    busRdata  = 32'h0;
    checkOutput("bb1_done", done, 1);
    checkOutput("bb1_rdata", rdata, 32'h0000_8000);
    checkOutput("bb1_ready", ready, 1);
    applyStimulus(1'b1, 32'h0000_7004, 32'h0, 1'b0, 2'b10, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
    checkOutput("bb2_bus_req", busReq, 1);
    checkOutput("bb2_bus_addr", busAddr, 32'h0000_7004);
    checkOutput("bb2_done_clear", done, 0);
    busGnt = 1'b1;
    nextCycle();
    busGnt    = 1'b0;
    busRvalid = 1'b1;
    busRdata  = 32'hDEAD_BEEF;
    nextCycle();
    busRvalid = 1'b0;
    busRdata  = 32'h0;
    checkOutput("bb2_done", done, 1);
    checkOutput("bb2_err", err, 0);
    checkOutput("bb2_rdata", rdata, 32'hDEAD_BEEF);
    nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
